// File: rtl/gear_ecu_adder.sv
// Sequential GeAr adder: speculative sub-adders with error detection and
// optional bottom-up carry correction, one repair per cycle.
module gear_ecu_adder #(
  parameter int N = 16,
  parameter int R = 2,
  parameter int P = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N-1:0]             a,
  input  logic [N-1:0]             b,
  input  logic                     cin,
  input  logic                     mode,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N-1:0]             sum,
  output logic                     cout,
  output logic                     err,
  output logic [((((N-R-P)/R+1) > 1) ? $clog2((N-R-P)/R+1) : 1)-1:0] corr_cnt
);

  localparam int K  = (N - R - P) / R + 1;
  localparam int CW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic [N-1:0]   a_r, b_r;
  logic           cin_r, mode_r;
  logic [K-1:0]   cinj_r, cinj_s;
  logic [CW-1:0]  cnt_r, cnt_s;

  logic [N-1:0]   sum_s;
  logic           cout_s;
  logic [K-1:0]   err_vec_s;
  logic [K-1:0]   fix_s;
  logic [R+P:0]   win_s;
  logic           carry_prev_s;
  logic           sub_cin_s;

  // Speculative sub-adder array; carry_prev_s is the lower neighbour's carry out of its low R bits.
  always_comb begin
    sum_s        = {N{1'b0}};
    err_vec_s    = {K{1'b0}};
    win_s        = {(R+P+1){1'b0}};
    carry_prev_s = 1'b0;
    sub_cin_s    = 1'b0;
    for (int j = 0; j < K; j++) begin
      if (j == 0) begin
        sub_cin_s = cin_r;
      end else if (cinj_r[j]) begin
        sub_cin_s = carry_prev_s;
      end else begin
        sub_cin_s = 1'b0;
      end
      err_vec_s[j] = ~cinj_r[j] & (&(a_r[j*R +: P] ^ b_r[j*R +: P])) & carry_prev_s;
      win_s = {1'b0, a_r[j*R +: R+P]} + {1'b0, b_r[j*R +: R+P]}
            + {{(R+P){1'b0}}, sub_cin_s};
      if (j == 0) begin
        sum_s[R+P-1:0] = win_s[R+P-1:0];
      end else begin
        sum_s[j*R+P +: R] = win_s[P +: R];
      end
      // Carry into window bit R recovered from the sum bit, avoiding a second adder.
      carry_prev_s = win_s[R] ^ a_r[j*R+R] ^ b_r[j*R+R];
    end
    cout_s = win_s[R+P];
  end

  // Isolate the lowest flagged sub-adder for the next repair.
  always_comb begin
    fix_s = err_vec_s & (~err_vec_s + K'(1));
  end

  // Next-state and correction bookkeeping.
  always_comb begin
    state_s = state_r;
    cinj_s  = cinj_r;
    cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          state_s = EVAL;
        end else begin
          state_s = IDLE;
        end
      end
      EVAL: begin
        if (!mode_r || (err_vec_s == {K{1'b0}})) begin
          state_s = HOLD;
        end else begin
          cinj_s = cinj_r | fix_s;
          cnt_s  = cnt_r + CW'(1);
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = HOLD;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, operand capture and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      a_r       <= {N{1'b0}};
      b_r       <= {N{1'b0}};
      cin_r     <= 1'b0;
      mode_r    <= 1'b0;
      cinj_r    <= {K{1'b0}};
      cnt_r     <= {CW{1'b0}};
      sum       <= {N{1'b0}};
      cout      <= 1'b0;
      err       <= 1'b0;
      corr_cnt  <= {CW{1'b0}};
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_r   <= state_s;
      out_valid <= (state_s == HOLD);
      in_ready  <= (state_s == IDLE);
      if ((state_r == IDLE) && in_valid) begin
        a_r    <= a;
        b_r    <= b;
        cin_r  <= cin;
        mode_r <= mode;
        cinj_r <= {K{1'b0}};
        cnt_r  <= {CW{1'b0}};
      end else begin
        cinj_r <= cinj_s;
        cnt_r  <= cnt_s;
      end
      if ((state_r == EVAL) && (state_s == HOLD)) begin
        sum      <= sum_s;
        cout     <= cout_s;
        err      <= |err_vec_s;
        corr_cnt <= cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_gear_ecu_adder.sv
// Directed and small random checks for gear_ecu_adder with default parameters.
module tb_gear_ecu_adder;
  localparam int N = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          cin = 1'b0;
  logic          mode = 1'b0;
  logic          out_ready = 1'b0;
  logic [N-1:0]  a = 16'h0000;
  logic [N-1:0]  b = 16'h0000;
  logic          in_ready, out_valid, cout, err;
  logic [N-1:0]  sum;
  logic [2:0]    corr_cnt;

  int checks = 0;
  int errors = 0;

  gear_ecu_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .mode(mode), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .err(err), .corr_cnt(corr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Issue one operation and wait (bounded) for out_valid; lat counts the accept edge as 1.
  task automatic start_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                          input logic tc, input logic tm, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 20) begin
      @(posedge clk); #1; guard++;
    end
    a = ta; b = tb; cin = tc; mode = tm; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_vec(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb,
                         input logic tc, input logic tm, input logic [N-1:0] es,
                         input logic ec, input logic ee, input int en, input int el);
    int lat;
    start_op(ta, tb, tc, tm, lat);
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_err"}, err, ee);
    chk({tag, "_cnt"}, corr_cnt, en);
    release_op();
  endtask

  initial begin
    int lat;
    logic [N:0] exact;
    logic [N-1:0] ra, rb;
    logic rc;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_err", err, 0);
    chk("rst_cnt", corr_cnt, 0);
    rst_n = 1'b1;
    chk("rst_in_ready", in_ready, 1);

    // Directed vectors: tag, a, b, cin, mode, sum, cout, err, cnt, latency
    run_vec("t1_m0",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 2);
    run_vec("t1_m1",  16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0, 1, 3);
    run_vec("t2_m0",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'hFF00, 1'b0, 1'b1, 0, 2);
    run_vec("t2_m1",  16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 4, 6);
    run_vec("t3_m0",  16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 0, 2);
    run_vec("t3_m1",  16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0, 0, 2);
    run_vec("t3_cin", 16'h00FF, 16'h0000, 1'b1, 1'b1, 16'h0100, 1'b0, 1'b0, 1, 3);

    // Backpressure with new operands presented while holding
    start_op(16'h00FF, 16'h0001, 1'b0, 1'b1, lat);
    chk("bp_valid", out_valid, 1);
    a = 16'hFFFF; b = 16'hFFFF; mode = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_sum", sum, 16'h0100);
      chk("bp_hold_cout", cout, 0);
      chk("bp_hold_err", err, 0);
      chk("bp_hold_cnt", corr_cnt, 1);
      chk("bp_hold_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_op();
    chk("bp_rel_valid", out_valid, 0);
    chk("bp_rel_in_ready", in_ready, 1);

    // Reset after the second correction
    a = 16'hFFFF; b = 16'h0001; cin = 1'b0; mode = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mr_valid", out_valid, 0);
    chk("mr_sum", sum, 0);
    chk("mr_cnt", corr_cnt, 0);
    chk("mr_in_ready", in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("mr_no_result", out_valid, 0);
    run_vec("mr_fresh", 16'h1234, 16'h1111, 1'b0, 1'b1, 16'h2345, 1'b0, 1'b0, 0, 2);

    // Random: exact mode must always be exact; approximate mode exact whenever err=0
    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      exact = {1'b0, ra} + {1'b0, rb} + {16'h0000, rc};
      start_op(ra, rb, rc, 1'b1, lat);
      chk("rnd1_sum", {cout, sum}, exact);
      chk("rnd1_err", err, 0);
      chk("rnd1_cnt_bound", (corr_cnt <= 3'd4), 1);
      chk("rnd1_lat", lat, 2 + corr_cnt);
      release_op();
      start_op(ra, rb, rc, 1'b0, lat);
      chk("rnd0_cnt", corr_cnt, 0);
      if (!err) begin
        chk("rnd0_sum", {cout, sum}, exact);
      end
      release_op();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
